// File: rtl/count_tracker.sv
`default_nettype none
// ============================================================================
// Module      : count_tracker
// Description : Follows a sampled 4-bit counter and classifies its motion as
//               unlocked, counting up or counting down. It reports wraps,
//               direction changes and illegal steps, and keeps a saturating
//               count of the illegal steps.
//               Optional feature macro: COUNT_TRACKER_LOAD_EN adds the ld and
//               ld_data ports, so that a known counter load is checked
//               against its load value instead of being judged as a step.
// Revision    : 1.0 - initial release
// ============================================================================
module count_tracker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic [3:0] cnt_in,
`ifdef COUNT_TRACKER_LOAD_EN
    input  logic       ld,
    input  logic [3:0] ld_data,
`endif
    output logic       locked,
    output logic       dir_up,
    output logic       dir_down,
    output logic       wrap,
    output logic       dir_chg,
    output logic       err,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_UNLOCKED  = 2'd0,
        ST_LOCK_UP   = 2'd1,
        ST_LOCK_DOWN = 2'd2
    } state_t;

    localparam logic [3:0] C_STEP_UP   = 4'd1;
    localparam logic [3:0] C_STEP_DOWN = 4'd15;
    localparam logic [3:0] C_STEP_HOLD = 4'd0;
    localparam logic [7:0] C_CNT_MAX   = 8'hFF;

    state_t     state_q, state_d;
    logic [3:0] prev_q, prev_d;
    logic       have_prev_q, have_prev_d;
    logic       wrap_q, wrap_d;
    logic       dir_chg_q, dir_chg_d;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic [3:0] delta;
    logic       load_hit;
    logic       load_bad;

    // Modulo-16 step between this sample and the previous one.
    assign delta = cnt_in - prev_q;

    // A load cycle is judged against ld_data instead of against the step rules.
`ifdef COUNT_TRACKER_LOAD_EN
    assign load_hit = ld;
    assign load_bad = (cnt_in != ld_data);
`else
    assign load_hit = 1'b0;
    assign load_bad = 1'b0;
`endif

    // Next-state, history and pulse computation for one sample.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        wrap_d      = 1'b0;
        dir_chg_d   = 1'b0;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (valid) begin
            prev_d      = cnt_in;
            have_prev_d = 1'b1;

            // The very first sample after reset only seeds the history.
            if (have_prev_q) begin
                if (load_hit) begin
                    if (load_bad) begin
                        err_d   = 1'b1;
                        state_d = ST_UNLOCKED;
                    end
                end else begin
                    case (state_q)
                        ST_UNLOCKED: begin
                            if (delta == C_STEP_UP) begin
                                state_d = ST_LOCK_UP;
                            end else if (delta == C_STEP_DOWN) begin
                                state_d = ST_LOCK_DOWN;
                            end
                        end
                        ST_LOCK_UP: begin
                            if (delta == C_STEP_UP) begin
                                wrap_d = (prev_q == 4'd15);
                            end else if (delta == C_STEP_DOWN) begin
                                state_d   = ST_LOCK_DOWN;
                                dir_chg_d = 1'b1;
                            end else if (delta != C_STEP_HOLD) begin
                                state_d = ST_UNLOCKED;
                                err_d   = 1'b1;
                            end
                        end
                        ST_LOCK_DOWN: begin
                            if (delta == C_STEP_DOWN) begin
                                wrap_d = (prev_q == 4'd0);
                            end else if (delta == C_STEP_UP) begin
                                state_d   = ST_LOCK_UP;
                                dir_chg_d = 1'b1;
                            end else if (delta != C_STEP_HOLD) begin
                                state_d = ST_UNLOCKED;
                                err_d   = 1'b1;
                            end
                        end
                        default: begin
                            state_d = ST_UNLOCKED;
                        end
                    endcase
                end
            end
        end

        if (err_d && (err_cnt_q != C_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State, history and pulse registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_UNLOCKED;
            prev_q      <= 4'd0;
            have_prev_q <= 1'b0;
            wrap_q      <= 1'b0;
            dir_chg_q   <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            wrap_q      <= wrap_d;
            dir_chg_q   <= dir_chg_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked   = (state_q == ST_LOCK_UP) || (state_q == ST_LOCK_DOWN);
    assign dir_up   = (state_q == ST_LOCK_UP);
    assign dir_down = (state_q == ST_LOCK_DOWN);
    assign wrap     = wrap_q;
    assign dir_chg  = dir_chg_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_count_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_tracker
// Description : Self-checking bench for count_tracker. Directed scenarios and
//               random sample streams are compared against a behavioural
//               model of the tracker kept in this file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_tracker;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic [3:0] cnt_in;
    logic       ld;
    logic [3:0] ld_data;
    logic       locked, dir_up, dir_down, wrap, dir_chg, err;
    logic [7:0] err_cnt;

    int n_checks;
    int n_errors;

    // Behavioural model: direction as +1 / -1 / 0 (unlocked).
    int m_dir;
    int m_prev;
    bit m_have;
    int m_cnt;
    bit m_wrap, m_chg, m_err;

    count_tracker dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid),
        .cnt_in   (cnt_in),
`ifdef COUNT_TRACKER_LOAD_EN
        .ld       (ld),
        .ld_data  (ld_data),
`endif
        .locked   (locked),
        .dir_up   (dir_up),
        .dir_down (dir_down),
        .wrap     (wrap),
        .dir_chg  (dir_chg),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dir  = 0;
        m_prev = 0;
        m_have = 0;
        m_cnt  = 0;
        m_wrap = 0;
        m_chg  = 0;
        m_err  = 0;
    endtask

    task automatic model_flag_err();
        m_err = 1;
        m_dir = 0;
        if (m_cnt < 255) m_cnt++;
    endtask

    // Apply one clock of the tracker rules to the model.
    task automatic model_step(input bit v, input int c, input bit l, input int ldv);
        int d;
        m_wrap = 0;
        m_chg  = 0;
        m_err  = 0;
        if (!v) return;
        if (!m_have) begin
            m_have = 1;
            m_prev = c;
            return;
        end
        d = (c - m_prev + 16) % 16;
        if (l) begin
            if (c != ldv) model_flag_err();
        end else if (m_dir == 0) begin
            if (d == 1) m_dir = 1;
            else if (d == 15) m_dir = -1;
        end else begin
            // Forward step is +1 when counting up, -1 (i.e. 15) when down.
            if (d == 0) begin
            end else if (d == ((m_dir == 1) ? 1 : 15)) begin
                m_wrap = (m_dir == 1) ? (m_prev == 15 && c == 0) : (m_prev == 0 && c == 15);
            end else if (d == ((m_dir == 1) ? 15 : 1)) begin
                m_dir = -m_dir;
                m_chg = 1;
            end else begin
                model_flag_err();
            end
        end
        m_prev = c;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".locked"},   32'(locked),   32'(m_dir != 0));
        check({tag, ".dir_up"},   32'(dir_up),   32'(m_dir == 1));
        check({tag, ".dir_down"}, 32'(dir_down), 32'(m_dir == -1));
        check({tag, ".wrap"},     32'(wrap),     32'(m_wrap));
        check({tag, ".dir_chg"},  32'(dir_chg),  32'(m_chg));
        check({tag, ".err"},      32'(err),      32'(m_err));
        check({tag, ".err_cnt"},  32'(err_cnt),  32'(m_cnt));
        check({tag, ".excl"},     32'(32'(wrap) + 32'(dir_chg) + 32'(err) <= 1), 32'd1);
    endtask

    // Drive one sample at the falling edge, check just after the rising edge.
    task automatic step(input string tag, input bit v, input logic [3:0] c);
        @(negedge clk);
        rst_n  = 1'b1;
        valid  = v;
        cnt_in = c;
        @(posedge clk);
        model_step(v, int'(c), ld, int'(ld_data));
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'b0;
        ld    = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        repeat (cycles) @(posedge clk);
        #1;
        check_all("reset_hold");
    endtask

    initial begin
        logic [3:0] cur;
        int         pick;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        valid    = 1'b0;
        cnt_in   = 4'd0;
        ld       = 1'b0;
        ld_data  = 4'd0;
        model_reset();

        // Lock up on 3,4,5,6.
        do_reset(2);
        step("up3", 1, 4'd3);
        step("up4", 1, 4'd4);
        check("up4.locked_now", 32'(locked), 32'd1);
        step("up5", 1, 4'd5);
        step("up6", 1, 4'd6);

        // Wrap while counting up.
        step("wr13", 1, 4'd13);   // delta 7 -> err, unlocked
        step("wr14", 1, 4'd14);   // relock up
        step("wr15", 1, 4'd15);
        step("wr0",  1, 4'd0);
        check("wr0.wrap_now", 32'(wrap), 32'd1);
        step("wr1",  1, 4'd1);

        // Hold then direction change: 8,9,9,9,8,7.
        step("dc8", 1, 4'd8);     // err from 1
        step("dc9", 1, 4'd9);
        step("dc9h", 1, 4'd9);
        step("dc9h2", 1, 4'd9);
        step("dc8b", 1, 4'd8);
        check("dc8b.chg_now", 32'(dir_chg), 32'd1);
        step("dc7", 1, 4'd7);

        // Wrap while counting down, and valid=0 freezes everything.
        step("dw1", 1, 4'd1);     // err from 7
        step("dw0", 1, 4'd0);
        step("idle", 0, 4'd9);
        step("idle2", 0, 4'd3);
        step("dw15", 1, 4'd15);
        check("dw15.wrap_now", 32'(wrap), 32'd1);

        // Lock down at 6, illegal jump to 2, then saturation after 300 errors.
        do_reset(1);
        step("ld7", 1, 4'd7);
        step("ld6", 1, 4'd6);
        step("err2", 1, 4'd2);
        check("err2.cnt_now", 32'(err_cnt), 32'd1);
        cur = 4'd2;
        for (int i = 0; i < 300; i++) begin
            cur = cur - 4'd1;
            step("sat_lock", 1, cur);
            cur = cur - 4'd4;
            step("sat_err", 1, cur);
        end
        check("sat.cnt_final", 32'(err_cnt), 32'd255);

        // Reset mid-track discards history; release coincides with a sample.
        do_reset(1);
        step("rl4", 1, 4'd4);
        step("rl5", 1, 4'd5);
        do_reset(2);
        step("rr5", 1, 4'd5);
        check("rr5.unlocked", 32'(locked), 32'd0);
        step("rr6", 1, 4'd6);
        check("rr6.locked", 32'(locked), 32'd1);

`ifdef COUNT_TRACKER_LOAD_EN
        // Matching load keeps the lock; next step continues from loaded value.
        step("lu1", 1, 4'd1);
        step("lu2", 1, 4'd2);
        ld      = 1'b1;
        ld_data = 4'd8;
        step("load8", 1, 4'd8);
        ld      = 1'b0;
        step("load9", 1, 4'd9);
        ld      = 1'b1;
        ld_data = 4'd3;
        step("loadbad", 1, 4'd4);
        ld      = 1'b0;
`endif

        // Random streams biased toward legal steps, with occasional resets.
        cur = 4'($urandom_range(0, 15));
        for (int i = 0; i < 3000; i++) begin
            pick = int'($urandom_range(0, 19));
            if (pick == 0 && ($urandom_range(0, 9) == 0)) begin
                do_reset(int'($urandom_range(1, 3)));
            end
            pick = int'($urandom_range(0, 19));
            if (pick < 7)       cur = cur + 4'd1;
            else if (pick < 13) cur = cur - 4'd1;
            else if (pick < 16) cur = cur;
            else                cur = 4'($urandom_range(0, 15));
`ifdef COUNT_TRACKER_LOAD_EN
            ld      = ($urandom_range(0, 15) == 0);
            ld_data = ($urandom_range(0, 1) == 0) ? cur : 4'($urandom_range(0, 15));
`endif
            step("rnd", ($urandom_range(0, 7) != 0), cur);
        end
        ld = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_tracker.md
COUNT_TRACKER -- requirements
Module: count_tracker

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 valid  input  1  high = cnt_in holds a new sample this cycle.
REQ-004 cnt_in  input  4  observed 4-bit counter value.
REQ-005 locked  output  1  high while the FSM is in LOCK_UP or LOCK_DOWN.
REQ-006 dir_up  output  1  high while in LOCK_UP.
REQ-007 dir_down  output  1  high while in LOCK_DOWN.
REQ-008 wrap  output  1  one-cycle pulse on a legal wrap (15->0 in LOCK_UP, 0->15 in LOCK_DOWN).
REQ-009 dir_chg  output  1  one-cycle pulse on a legal LOCK_UP<->LOCK_DOWN change.
REQ-010 err  output  1  one-cycle pulse on an illegal step while locked.
REQ-011 err_cnt  output  8  saturating count of err pulses.
REQ-012 ld, ld_data  input  1, 4  present only when COUNT_TRACKER_LOAD_EN is defined (REQ-029).

Function
REQ-013 All outputs SHALL be registered; a response appears on the rising edge after the valid sample.
REQ-014 prev (4 bits) and have_prev (1 bit) SHALL latch cnt_in on every valid sample; have_prev SHALL then be set.
REQ-015 delta = (cnt_in - prev) mod 16, evaluated only when valid=1 and have_prev=1.
REQ-016 FSM states: UNLOCKED, LOCK_UP, LOCK_DOWN.
REQ-017 UNLOCKED: delta 1 -> LOCK_UP; delta 15 -> LOCK_DOWN; any other delta -> stay; err SHALL NOT assert.
REQ-018 LOCK_UP: delta 0 -> stay (hold); delta 1 -> stay; delta 15 -> LOCK_DOWN with dir_chg pulse; any other delta -> UNLOCKED with err pulse.
REQ-019 LOCK_DOWN: mirror of REQ-018 (delta 15 stays, delta 1 -> LOCK_UP with dir_chg pulse, delta 0 holds, any other delta -> err, UNLOCKED).
REQ-020 wrap SHALL pulse in LOCK_UP on prev=15, cnt_in=0, and in LOCK_DOWN on prev=0, cnt_in=15; it SHALL NOT pulse in UNLOCKED or on the locking step.
REQ-021 The first valid sample after reset SHALL only set prev and have_prev; no state change and no pulses.
REQ-022 valid=0 SHALL freeze the FSM, prev and err_cnt; pulses SHALL deassert.
REQ-023 err_cnt SHALL increment by 1 per err pulse and saturate at 255.
REQ-024 wrap, dir_chg and err SHALL be mutually exclusive in any cycle.

Reset
REQ-025 rst_n low SHALL immediately force: FSM=UNLOCKED, have_prev=0, prev=0, and locked, dir_up, dir_down, wrap, dir_chg, err=0, err_cnt=0.
REQ-026 Reset asserted mid-track SHALL discard history; the first valid sample after release follows REQ-021.
REQ-027 A valid sample in the same cycle as reset release SHALL be processed as the first sample.

Configuration
REQ-028 Macro COUNT_TRACKER_LOAD_EN SHALL control load-aware tracking.
REQ-029 Defined: ports ld and ld_data exist. On valid=1 with ld=1: if cnt_in==ld_data, there is no err, the FSM is unchanged, wrap and dir_chg stay low, and prev=cnt_in. If cnt_in!=ld_data, err pulses, err_cnt increments, the FSM goes to UNLOCKED and prev=cnt_in.
REQ-030 Undefined: ld and ld_data SHALL be absent, and every jump is judged by REQ-017 to REQ-019 alone.

Verification
REQ-031 Reset, then valid samples 3,4,5,6 -> locked=1 and dir_up=1 after the sample 4 edge; err_cnt=0.
REQ-032 Locked up, samples 14,15,0,1 -> one wrap pulse, on the edge after sample 0.
REQ-033 Locked up at 9, samples 9,9,8,7 -> holds on the 9s, dir_chg pulse after 8, then dir_down=1.
REQ-034 Locked down at 6, sample 2 -> err pulse, locked=0, err_cnt=1; 300 such errors -> err_cnt=255.
REQ-035 Locked up at 5, rst_n low for 2 cycles, release, then samples 5,6 -> no pulses, and lock only after the 6 sample.
REQ-036 With COUNT_TRACKER_LOAD_EN, locked up at 2, ld=1, ld_data=8, cnt_in=8 -> no err, still LOCK_UP; next sample 9 -> stays locked.
